ll_window_ctrl: RTL

//  Scheduler/controller for line-length feature extraction over NUM_CH EEG channels.

---
 rtl/ll_pkg.sv | 26 ++
 rtl/ll_window_ctrl_if.sv | 29 ++
 rtl/ll_acc_unit.sv | 27 ++
 rtl/ll_window_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared types and helpers for the line-length window controller.
// Optional output normalisation is selected by the LL_NORM_EN macro (see ll_window_ctrl).
package ll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    EMIT
  } ll_state_e;

  // Widest sample the abs_diff helper supports.
  localparam int unsigned ABS_MAX_W = 64;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Operands arrive sign-extended, so the magnitude of the difference always fits ABS_MAX_W bits.
  function automatic logic [ABS_MAX_W-1:0] abs_diff(input logic signed [ABS_MAX_W:0] a,
                                                    input logic signed [ABS_MAX_W:0] b);
    logic signed [ABS_MAX_W+1:0] d;
    d = {a[ABS_MAX_W], a} - {b[ABS_MAX_W], b};
    return d[ABS_MAX_W+1] ? ABS_MAX_W'(-d) : ABS_MAX_W'(d);
  endfunction

endpackage

// File: rtl/ll_window_ctrl_if.sv
// Frame input and result output handshakes of the line-length window controller.
interface ll_window_ctrl_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 40
);
  import ll_pkg::*;

  localparam int unsigned CH_W = idx_width(NUM_CH);

  logic                         s_valid;
  logic                         s_ready;
  logic [NUM_CH*DATA_WIDTH-1:0] s_data;
  logic                         m_valid;
  logic                         m_ready;
  logic [CH_W-1:0]              m_ch;
  logic [ACC_WIDTH-1:0]         m_ll;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_ch, m_ll
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_ch, m_ll
  );

endinterface

// File: rtl/ll_acc_unit.sv
// Combinational |x - prev| plus saturating accumulate, shared across all channels.
module ll_acc_unit
  import ll_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic signed [DATA_WIDTH-1:0] prev,
  input  logic                         prev_vld,
  input  logic [ACC_WIDTH-1:0]         acc_in,
  output logic [ACC_WIDTH-1:0]         acc_out
);

  // Sum is kept wide enough for both operands; any bit above ACC_WIDTH means saturation.
  localparam int unsigned SUM_W = ((ACC_WIDTH > ABS_MAX_W) ? ACC_WIDTH : ABS_MAX_W) + 1;

  logic [ABS_MAX_W-1:0] mag;
  logic [SUM_W-1:0]     sum;

  always_comb begin
    mag     = prev_vld ? abs_diff((ABS_MAX_W+1)'(x), (ABS_MAX_W+1)'(prev)) : '0;
    sum     = SUM_W'(acc_in) + SUM_W'(mag);
    acc_out = (|sum[SUM_W-1:ACC_WIDTH]) ? '1 : sum[ACC_WIDTH-1:0];
  end

endmodule

// File: rtl/ll_window_ctrl.sv
// Line-length window scheduler: one shared ll_acc_unit walks the channels of each frame.
// Define LL_NORM_EN to report the per-frame mean (acc >> log2(WIN_LEN)) instead of the raw sum.
module ll_window_ctrl
  import ll_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIN_LEN    = 256,
  parameter int unsigned ACC_WIDTH  = 40
) (
  input  logic             clk,
  input  logic             rst,
  ll_window_ctrl_if.slave  bus,
  output logic             busy
);

  localparam int unsigned CH_W = idx_width(NUM_CH);
  localparam int unsigned FC_W = $clog2(WIN_LEN);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [FC_W-1:0] LAST_FRM = FC_W'(WIN_LEN - 1);

  ll_state_e state, state_nx;

  logic [NUM_CH*DATA_WIDTH-1:0] frame_q;
  logic [CH_W-1:0]              ch_idx;
  logic [FC_W-1:0]              frame_cnt;
  logic [ACC_WIDTH-1:0]         acc  [NUM_CH];
  logic signed [DATA_WIDTH-1:0] prev [NUM_CH];
  logic                         prev_vld;

  logic signed [DATA_WIDTH-1:0] x_cur;
  logic [ACC_WIDTH-1:0]         acc_nx;
  logic [ACC_WIDTH-1:0]         ll_out;
  logic                         last_ch;
  logic                         win_end;

  ll_acc_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_acc (
    .x        (x_cur),
    .prev     (prev[ch_idx]),
    .prev_vld (prev_vld),
    .acc_in   (acc[ch_idx]),
    .acc_out  (acc_nx)
  );

  always_comb begin
    x_cur   = frame_q[ch_idx*DATA_WIDTH +: DATA_WIDTH];
    last_ch = (ch_idx == LAST_CH);
    win_end = (frame_cnt == LAST_FRM);
`ifdef LL_NORM_EN
    ll_out  = acc[ch_idx] >> FC_W;
`else
    ll_out  = acc[ch_idx];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.s_ready = (state == IDLE) & rst;
    bus.m_valid = (state == EMIT);
    bus.m_ch    = ch_idx;
    bus.m_ll    = (state == EMIT) ? ll_out : '0;
    busy        = (state != IDLE);
    case (state)
      IDLE:    if (bus.s_valid) state_nx = PROC;
      PROC:    if (last_ch) state_nx = win_end ? EMIT : IDLE;
      EMIT:    if (bus.m_ready && last_ch) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ch_idx returns to 0 whenever PROC or EMIT finishes, so m_ch reads 0 while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q   <= '0;
      ch_idx    <= '0;
      frame_cnt <= '0;
      prev_vld  <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc[i]  <= '0;
        prev[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.s_valid) begin
            frame_q <= bus.s_data;
            ch_idx  <= '0;
          end
        end
        PROC: begin
          acc[ch_idx]  <= acc_nx;
          prev[ch_idx] <= x_cur;
          if (last_ch) begin
            prev_vld  <= 1'b1;
            ch_idx    <= '0;
            frame_cnt <= win_end ? '0 : frame_cnt + 1'b1;
          end else begin
            ch_idx <= ch_idx + 1'b1;
          end
        end
        EMIT: begin
          if (bus.m_ready) begin
            acc[ch_idx] <= '0;
            ch_idx      <= last_ch ? '0 : ch_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
